// File: rtl/can_frame_rx_if.sv
// can_frame_rx_if
// Groups the receiver's serial input and its decoded outputs.
//   bus_in, bit_en           : resolved bus level and sample strobe (into the receiver)
//   id, dlc, data_out        : decoded identifier, DLC and most recent data byte
//   data_valid, frame_valid,
//   stuff_err, crc_err,
//   form_err                 : single-cycle event pulses
//   busy                     : a frame is in progress
// The slave modport is the receiver side. The master modport is the side that drives the bus.
interface can_frame_rx_if;
    logic       bus_in;
    logic       bit_en;
    logic [7:0] id;
    logic [3:0] dlc;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_valid;
    logic       stuff_err;
    logic       crc_err;
    logic       form_err;
    logic       busy;

    modport master (
        output bus_in, bit_en,
        input  id, dlc, data_out, data_valid, frame_valid,
               stuff_err, crc_err, form_err, busy
    );

    modport slave (
        input  bus_in, bit_en,
        output id, dlc, data_out, data_valid, frame_valid,
               stuff_err, crc_err, form_err, busy
    );
endinterface

// File: rtl/can_frame_rx.sv
// can_frame_rx
// CAN-style serial frame receiver. It performs SOF detection, bit destuffing and
// CRC-15 checking. It decodes an 8-bit identifier, the 4-bit DLC and up to
// MAX_BYTES data bytes.
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active low
//   bus  : can_frame_rx_if.slave
//          inputs  bus_in, bit_en
//          outputs id, dlc, data_out, data_valid, frame_valid,
//                  stuff_err, crc_err, form_err, busy
// The receiver consumes a bus bit only in cycles where bit_en is high.
// All outputs are registered.
module can_frame_rx #(
    parameter int IDLE_BITS = 7,
    parameter int MAX_BYTES = 8
) (
    input  logic           clk,
    input  logic           rst,
    can_frame_rx_if.slave  bus
);
    localparam int              IW        = (IDLE_BITS < 2) ? 1 : $clog2(IDLE_BITS);
    localparam logic [IW-1:0]   IDLE_LAST = IW'(IDLE_BITS - 1);
    localparam logic [3:0]      MAX_N     = 4'(MAX_BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_ID, S_DLC, S_DATA, S_CRC, S_CRC_DEL, S_WAIT_IDLE
    } state_t;

    state_t          state_reg;
    logic            run_val_reg;
    logic [2:0]      run_len_reg;
    logic [14:0]     crc_reg;
    logic [13:0]     crc_rx_reg;
    logic [6:0]      shift_reg;
    logic [3:0]      bit_cnt_reg;
    logic [3:0]      byte_cnt_reg;
    logic [3:0]      nbytes_reg;
    logic [IW-1:0]   idle_cnt_reg;
    logic [7:0]      id_reg;
    logic [3:0]      dlc_reg;
    logic [7:0]      data_reg;
    logic            data_valid_reg;
    logic            frame_valid_reg;
    logic            stuff_err_reg;
    logic            crc_err_reg;
    logic            form_err_reg;
    logic            busy_reg;

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        logic fb;
        fb = b ^ c[14];
        return {c[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
    endfunction

    logic        b;
    logic        in_stuffed;
    logic        is_stuff;
    logic [7:0]  shift_in;
    logic [3:0]  dlc_in;
    logic [3:0]  n_in;
    logic [14:0] crc_rx_in;
    logic [14:0] crc_upd;

    assign b          = bus.bus_in;
    // The destuffing region is SOF through the last CRC bit. CRC_DEL is never a stuff bit.
    assign in_stuffed = (state_reg == S_ID) || (state_reg == S_DLC) ||
                        (state_reg == S_DATA) || (state_reg == S_CRC);
    assign is_stuff   = in_stuffed && (run_len_reg == 3'd5);
    assign shift_in   = {shift_reg, b};
    assign dlc_in     = {shift_reg[2:0], b};
    assign n_in       = (dlc_in > MAX_N) ? MAX_N : dlc_in;
    assign crc_rx_in  = {crc_rx_reg, b};
    assign crc_upd    = crc_step(crc_reg, b);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= S_IDLE;
            run_val_reg     <= 1'b0;
            run_len_reg     <= 3'd0;
            crc_reg         <= 15'h0;
            crc_rx_reg      <= 14'h0;
            shift_reg       <= 7'h0;
            bit_cnt_reg     <= 4'd0;
            byte_cnt_reg    <= 4'd0;
            nbytes_reg      <= 4'd0;
            idle_cnt_reg    <= '0;
            id_reg          <= 8'h0;
            dlc_reg         <= 4'h0;
            data_reg        <= 8'h0;
            data_valid_reg  <= 1'b0;
            frame_valid_reg <= 1'b0;
            stuff_err_reg   <= 1'b0;
            crc_err_reg     <= 1'b0;
            form_err_reg    <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            // Pulses last one clock whatever the bit_en duty cycle is.
            data_valid_reg  <= 1'b0;
            frame_valid_reg <= 1'b0;
            stuff_err_reg   <= 1'b0;
            crc_err_reg     <= 1'b0;
            form_err_reg    <= 1'b0;
            if (bus.bit_en) begin
                if (is_stuff) begin
                    if (b == run_val_reg) begin
                        stuff_err_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        idle_cnt_reg  <= '0;
                        state_reg     <= S_WAIT_IDLE;
                    end else begin
                        // Drop the stuff bit. It starts a new run.
                        run_val_reg <= b;
                        run_len_reg <= 3'd1;
                    end
                end else begin
                    if (in_stuffed) begin
                        if (b == run_val_reg) begin
                            run_len_reg <= run_len_reg + 3'd1;
                        end else begin
                            run_val_reg <= b;
                            run_len_reg <= 3'd1;
                        end
                    end
                    case (state_reg)
                        S_IDLE: begin
                            if (!b) begin
                                // A SOF bit of 0 leaves a zero CRC at zero.
                                state_reg   <= S_ID;
                                busy_reg    <= 1'b1;
                                run_val_reg <= 1'b0;
                                run_len_reg <= 3'd1;
                                crc_reg     <= 15'h0;
                                bit_cnt_reg <= 4'd0;
                            end
                        end
                        S_ID: begin
                            shift_reg   <= shift_in[6:0];
                            crc_reg     <= crc_upd;
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            if (bit_cnt_reg == 4'd7) begin
                                id_reg      <= shift_in;
                                bit_cnt_reg <= 4'd0;
                                state_reg   <= S_DLC;
                            end
                        end
                        S_DLC: begin
                            shift_reg   <= shift_in[6:0];
                            crc_reg     <= crc_upd;
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            if (bit_cnt_reg == 4'd3) begin
                                dlc_reg      <= dlc_in;
                                nbytes_reg   <= n_in;
                                byte_cnt_reg <= 4'd0;
                                bit_cnt_reg  <= 4'd0;
                                state_reg    <= (n_in == 4'd0) ? S_CRC : S_DATA;
                            end
                        end
                        S_DATA: begin
                            shift_reg   <= shift_in[6:0];
                            crc_reg     <= crc_upd;
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            if (bit_cnt_reg == 4'd7) begin
                                data_reg       <= shift_in;
                                data_valid_reg <= 1'b1;
                                bit_cnt_reg    <= 4'd0;
                                byte_cnt_reg   <= byte_cnt_reg + 4'd1;
                                if (byte_cnt_reg + 4'd1 == nbytes_reg) begin
                                    state_reg <= S_CRC;
                                end
                            end
                        end
                        S_CRC: begin
                            // The received CRC bits are not part of the CRC computation.
                            crc_rx_reg  <= crc_rx_in[13:0];
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            if (bit_cnt_reg == 4'd14) begin
                                bit_cnt_reg <= 4'd0;
                                if (crc_rx_in != crc_reg) begin
                                    crc_err_reg  <= 1'b1;
                                    busy_reg     <= 1'b0;
                                    idle_cnt_reg <= '0;
                                    state_reg    <= S_WAIT_IDLE;
                                end else begin
                                    state_reg <= S_CRC_DEL;
                                end
                            end
                        end
                        S_CRC_DEL: begin
                            frame_valid_reg <= b;
                            form_err_reg    <= ~b;
                            busy_reg        <= 1'b0;
                            idle_cnt_reg    <= '0;
                            state_reg       <= S_WAIT_IDLE;
                        end
                        S_WAIT_IDLE: begin
                            if (!b) begin
                                idle_cnt_reg <= '0;
                            end else if (idle_cnt_reg == IDLE_LAST) begin
                                idle_cnt_reg <= '0;
                                state_reg    <= S_IDLE;
                            end else begin
                                idle_cnt_reg <= idle_cnt_reg + 1'b1;
                            end
                        end
                        default: state_reg <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.id          = id_reg;
    assign bus.dlc         = dlc_reg;
    assign bus.data_out    = data_reg;
    assign bus.data_valid  = data_valid_reg;
    assign bus.frame_valid = frame_valid_reg;
    assign bus.stuff_err   = stuff_err_reg;
    assign bus.crc_err     = crc_err_reg;
    assign bus.form_err    = form_err_reg;
    assign bus.busy        = busy_reg;
endmodule

// File: tb/tb_can_frame_rx.sv
module tb_can_frame_rx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    can_frame_rx_if bus_if();

    can_frame_rx #(.IDLE_BITS(7), .MAX_BYTES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // Event counters that the negedge monitor keeps, totalled over the whole run
    int dv_cnt = 0, fv_cnt = 0, se_cnt = 0, ce_cnt = 0, fe_cnt = 0;
    int wide_cnt = 0, busy_bad = 0;
    logic [7:0] rx_bytes[$];
    logic dv_p = 0, fv_p = 0, se_p = 0, ce_p = 0, fe_p = 0, busy_p = 0;

    always @(negedge clk) begin
        logic term;
        if (bus_if.data_valid) begin
            dv_cnt++;
            rx_bytes.push_back(bus_if.data_out);
        end
        if (bus_if.frame_valid) fv_cnt++;
        if (bus_if.stuff_err)   se_cnt++;
        if (bus_if.crc_err)     ce_cnt++;
        if (bus_if.form_err)    fe_cnt++;
        if ((bus_if.data_valid & dv_p) | (bus_if.frame_valid & fv_p) |
            (bus_if.stuff_err & se_p) | (bus_if.crc_err & ce_p) | (bus_if.form_err & fe_p))
            wide_cnt++;
        term = bus_if.frame_valid | bus_if.stuff_err | bus_if.crc_err | bus_if.form_err;
        if (term && (bus_if.busy || !busy_p)) busy_bad++;
        dv_p = bus_if.data_valid; fv_p = bus_if.frame_valid; se_p = bus_if.stuff_err;
        ce_p = bus_if.crc_err;    fe_p = bus_if.form_err;    busy_p = bus_if.busy;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  id;
        logic [3:0]  dlc;
        logic [63:0] data;     // byte 0 in [63:56]
        int          flip;     // index of the CRC bit to invert, counted from the MSB, or -1 for none
        logic        del;      // level driven on the CRC delimiter
        int          period;   // number of clocks per bit_en strobe
        int          exp_dv, exp_fv, exp_ce, exp_fe;
    } vec_t;

    bit tx_q[$];

    // Build the frame: destuffed bits, then the bench CRC, then stuff bits, then CRC_DEL.
    task automatic build(input logic [7:0] fid, input logic [3:0] fdlc, input logic [63:0] fdata,
                         input int flip, input logic del);
        bit raw[$];
        logic [14:0] c;
        logic [7:0] bt;
        logic fb;
        bit rv;
        int rl, n;
        raw.push_back(1'b0);
        for (int i = 7; i >= 0; i--) raw.push_back(fid[i]);
        for (int i = 3; i >= 0; i--) raw.push_back(fdlc[i]);
        n = (fdlc > 4'd8) ? 8 : int'(fdlc);
        for (int k = 0; k < n; k++) begin
            bt = fdata[63 - 8*k -: 8];
            for (int i = 7; i >= 0; i--) raw.push_back(bt[i]);
        end
        c = 15'h0;
        foreach (raw[j]) begin
            fb = raw[j] ^ c[14];
            c = {c[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0);
        end
        for (int i = 14; i >= 0; i--) raw.push_back(c[i]);
        if (flip >= 0) raw[raw.size() - 15 + flip] = !raw[raw.size() - 15 + flip];
        tx_q.delete();
        rv = raw[0]; rl = 1;
        tx_q.push_back(raw[0]);
        for (int j = 1; j < raw.size(); j++) begin
            tx_q.push_back(raw[j]);
            if (raw[j] == rv) rl++;
            else begin rv = raw[j]; rl = 1; end
            if (rl == 5 && j != raw.size() - 1) begin
                tx_q.push_back(!rv);
                rv = !rv; rl = 1;
            end
        end
        tx_q.push_back(del);
    endtask

    task automatic send_bit(input logic b, input int period);
        bus_if.bus_in = b;
        bus_if.bit_en = 1'b1;
        @(posedge clk); #1;
        bus_if.bit_en = 1'b0;
        repeat (period - 1) begin @(posedge clk); #1; end
    endtask

    task automatic send_ones(input int n, input int period);
        for (int i = 0; i < n; i++) send_bit(1'b1, period);
    endtask

    task automatic send_tx(input int period);
        foreach (tx_q[i]) send_bit(tx_q[i], period);
    endtask

    vec_t vecs[6];

    initial begin
        int b_dv, b_fv, b_se, b_ce, b_fe, b_w, b_bb;
        bus_if.bus_in = 1'b1;
        bus_if.bit_en = 1'b0;

        vecs[0] = '{8'hE6, 4'd1,  64'hC700000000000000, -1, 1'b1, 1, 1, 1, 0, 0};
        vecs[1] = '{8'h00, 4'd0,  64'h0,                -1, 1'b1, 1, 0, 1, 0, 0};
        vecs[2] = '{8'h5A, 4'd2,  64'h1234000000000000,  3, 1'b1, 1, 2, 0, 1, 0};
        vecs[3] = '{8'h81, 4'd12, 64'h0123456789ABCDEF, -1, 1'b1, 1, 8, 1, 0, 0};
        vecs[4] = '{8'h3C, 4'd3,  64'hFF00F00000000000, -1, 1'b0, 1, 3, 0, 0, 1};
        vecs[5] = '{8'hE6, 4'd1,  64'hC700000000000000, -1, 1'b1, 3, 1, 1, 0, 0};

        #12;
        check("rst_id", {56'h0, bus_if.id}, 64'h0);
        check("rst_dlc", {60'h0, bus_if.dlc}, 64'h0);
        check("rst_data", {56'h0, bus_if.data_out}, 64'h0);
        check("rst_pulses", {59'h0, bus_if.data_valid, bus_if.frame_valid, bus_if.stuff_err,
                             bus_if.crc_err, bus_if.form_err}, 64'h0);
        check("rst_busy", {63'h0, bus_if.busy}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        for (int v = 0; v < 6; v++) begin
            b_dv = dv_cnt; b_fv = fv_cnt; b_se = se_cnt; b_ce = ce_cnt; b_fe = fe_cnt;
            b_w = wide_cnt; b_bb = busy_bad;
            build(vecs[v].id, vecs[v].dlc, vecs[v].data, vecs[v].flip, vecs[v].del);
            send_tx(vecs[v].period);
            send_ones(10, vecs[v].period);
            repeat (2) begin @(posedge clk); #1; end
            check($sformatf("v%0d_dv_count", v), 64'(dv_cnt - b_dv), 64'(vecs[v].exp_dv));
            for (int k = 0; k < vecs[v].exp_dv && b_dv + k < rx_bytes.size(); k++)
                check($sformatf("v%0d_byte%0d", v, k), {56'h0, rx_bytes[b_dv + k]},
                      {56'h0, vecs[v].data[63 - 8*k -: 8]});
            check($sformatf("v%0d_frame_valid", v), 64'(fv_cnt - b_fv), 64'(vecs[v].exp_fv));
            check($sformatf("v%0d_crc_err", v), 64'(ce_cnt - b_ce), 64'(vecs[v].exp_ce));
            check($sformatf("v%0d_form_err", v), 64'(fe_cnt - b_fe), 64'(vecs[v].exp_fe));
            check($sformatf("v%0d_stuff_err", v), 64'(se_cnt - b_se), 64'h0);
            check($sformatf("v%0d_id", v), {56'h0, bus_if.id}, {56'h0, vecs[v].id});
            check($sformatf("v%0d_dlc", v), {60'h0, bus_if.dlc}, {60'h0, vecs[v].dlc});
            check($sformatf("v%0d_busy", v), {63'h0, bus_if.busy}, 64'h0);
            check($sformatf("v%0d_pulse_width", v), 64'(wide_cnt - b_w), 64'h0);
            check($sformatf("v%0d_busy_edge", v), 64'(busy_bad - b_bb), 64'h0);
            $display("vector %0d: id=%0h dlc=%0d period=%0d dv=%0d fv=%0d crc_err=%0d form_err=%0d",
                     v, bus_if.id, bus_if.dlc, vecs[v].period, dv_cnt - b_dv, fv_cnt - b_fv,
                     ce_cnt - b_ce, fe_cnt - b_fe);
        end

        // Stuff violation: SOF followed by four ID zeros, then a 0 where the stuff bit belongs
        b_se = se_cnt; b_fv = fv_cnt;
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1);
        check("stuff_busy_before", {63'h0, bus_if.busy}, 64'h1);
        send_bit(1'b0, 1);
        check("stuff_err_pulse", {63'h0, bus_if.stuff_err}, 64'h1);
        check("stuff_busy_after", {63'h0, bus_if.busy}, 64'h0);
        send_ones(10, 1);
        check("stuff_err_count", 64'(se_cnt - b_se), 64'h1);
        check("stuff_no_fv", 64'(fv_cnt - b_fv), 64'h0);
        $display("stuff sequence: stuff_err=%0d", se_cnt - b_se);

        // Idle gap: a dominant bit during WAIT_IDLE restarts the recessive count
        b_fv = fv_cnt; b_se = se_cnt; b_ce = ce_cnt; b_fe = fe_cnt;
        build(8'hE6, 4'd1, 64'hC700000000000000, -1, 1'b1);
        send_tx(1);
        send_ones(3, 1);
        send_bit(1'b0, 1);
        send_ones(6, 1);
        send_bit(1'b0, 1);
        check("idle_no_sof", {63'h0, bus_if.busy}, 64'h0);
        send_ones(7, 1);
        send_bit(tx_q[0], 1);
        check("idle_sof_ok", {63'h0, bus_if.busy}, 64'h1);
        for (int i = 1; i < tx_q.size(); i++) send_bit(tx_q[i], 1);
        send_ones(10, 1);
        check("idle_fv_count", 64'(fv_cnt - b_fv), 64'h2);
        check("idle_no_err", 64'((se_cnt - b_se) + (ce_cnt - b_ce) + (fe_cnt - b_fe)), 64'h0);
        $display("idle sequence: frame_valid=%0d", fv_cnt - b_fv);

        // Reset asserted in the middle of the DATA field
        b_dv = dv_cnt;
        build(8'h5A, 4'd2, 64'h1234000000000000, -1, 1'b1);
        for (int i = 0; i < 25; i++) send_bit(tx_q[i], 1);
        check("mid_busy", {63'h0, bus_if.busy}, 64'h1);
        check("mid_data", {56'h0, bus_if.data_out}, 64'h12);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_id", {56'h0, bus_if.id}, 64'h0);
        check("mid_rst_dlc", {60'h0, bus_if.dlc}, 64'h0);
        check("mid_rst_data", {56'h0, bus_if.data_out}, 64'h0);
        check("mid_rst_flags", {58'h0, bus_if.data_valid, bus_if.frame_valid, bus_if.stuff_err,
                                bus_if.crc_err, bus_if.form_err, bus_if.busy}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        send_ones(3, 1);
        check("mid_rst_quiet", 64'(dv_cnt - b_dv), 64'h1);
        $display("reset sequence: data_valid before reset=%0d", dv_cnt - b_dv);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
